// File: rtl/imem_boot_ctrl.sv
// Instruction memory port owner: boot-load writes, then CPU fetch reads.
// Ports: clk/reset, load_* stream in, fetch_* CPU side, mem_* memory side.
module imem_boot_ctrl #(
  parameter int n = 32,
  parameter int r = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_start,
  input  logic         load_valid,
  input  logic [n-1:0] load_data,
  input  logic         load_last,
  output logic         load_ready,
  output logic         load_done,
  output logic [r:0]   load_count,
  input  logic         fetch_req,
  input  logic [r-1:0] fetch_addr,
  output logic         fetch_valid,
  output logic [n-1:0] fetch_data,
  output logic         cpu_stall,
  output logic         mem_we,
  output logic [r-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    BOOT,
    LOAD,
    RUN
  } state_t;

  localparam logic [r-1:0] PTR_ONE = 1;
  localparam logic [r:0]   CNT_ONE = 1;
  localparam logic [r-1:0] PTR_TOP = '1;

  state_t       state;
  state_t       state_nxt;
  logic [r-1:0] wptr;
  logic         beat;
  logic         fin;
  logic         fetch_go;
  logic         restart;

  always_comb begin
    state_nxt  = state;
    cpu_stall  = 1'b1;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = wptr;
    mem_wdata  = load_data;
    beat       = 1'b0;
    fin        = 1'b0;
    fetch_go   = 1'b0;
    restart    = 1'b0;
    unique case (state)
      BOOT: begin
        if (load_start) begin
          state_nxt = LOAD;
          restart   = 1'b1;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        mem_we     = load_valid;
        beat       = load_valid;
        // last flagged beat or the top address both close the load
        fin = load_valid & (load_last | (wptr == PTR_TOP));
        if (fin) state_nxt = RUN;
      end
      RUN: begin
        cpu_stall = 1'b0;
        mem_addr  = fetch_addr;
        // a restart wins over a same-cycle fetch, which is dropped
        if (load_start) begin
          state_nxt = LOAD;
          restart   = 1'b1;
        end else begin
          fetch_go = fetch_req;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      wptr        <= '0;
      load_count  <= '0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
    end else begin
      state       <= state_nxt;
      load_done   <= fin;
      fetch_valid <= fetch_go;
      if (fetch_go) fetch_data <= mem_rdata;
      if (restart) begin
        wptr       <= '0;
        load_count <= '0;
      end else if (beat) begin
        wptr       <= wptr + PTR_ONE;
        load_count <= load_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl with a behavioural 128x32 memory.
// Ports: drives all DUT inputs, checks all DUT outputs against constants.
module tb_imem_boot_ctrl;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic [7:0]  load_count;
  logic        fetch_req;
  logic [6:0]  fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        cpu_stall;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [128];

  int checks;
  int failures;

  imem_boot_ctrl #(.n(32), .r(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .cpu_stall  (cpu_stall),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_we) mem[mem_addr] <= mem_wdata;

  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        ls;
    logic        lv;
    logic [31:0] ld;
    logic        ll;
    logic        fr;
    logic [6:0]  fa;
    logic        e_stall;
    logic        e_ready;
    logic        e_we;
    logic        chk_addr;
    logic [6:0]  e_addr;
    logic        e_done;
    logic [7:0]  e_cnt;
    logic        e_fv;
    logic [31:0] e_fd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ls, input logic lv, input logic [31:0] ld,
                       input logic ll, input logic fr, input logic [6:0] fa);
    @(negedge clk);
    load_start = ls;
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    fetch_req  = fr;
    fetch_addr = fa;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic ls, input logic lv,
      input logic [31:0] ld, input logic ll, input logic fr,
      input logic [6:0] fa, input logic st, input logic rd, input logic we,
      input logic ca, input logic [6:0] ea, input logic dn,
      input logic [7:0] cn, input logic fv, input logic [31:0] fd);
    vec_t v;
    v.ls = ls; v.lv = lv; v.ld = ld; v.ll = ll; v.fr = fr; v.fa = fa;
    v.e_stall = st; v.e_ready = rd; v.e_we = we;
    v.chk_addr = ca; v.e_addr = ea;
    v.e_done = dn; v.e_cnt = cn; v.e_fv = fv; v.e_fd = fd;
    return v;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    load_start = 0; load_valid = 0; load_data = 0;
    load_last = 0; fetch_req = 0; fetch_addr = 0;

    // ls lv data ll fr fa | stall ready we chkaddr addr | done cnt fv fd
    vecs[0]  = mk(0,0,32'h0,0,0,7'd0, 1,0,0,0,7'd0, 0,8'd0,0,32'h0);
    vecs[1]  = mk(0,0,32'h0,0,0,7'd0, 1,0,0,0,7'd0, 0,8'd0,0,32'h0);
    vecs[2]  = mk(0,1,32'h1234,0,1,7'd0, 1,0,0,0,7'd0, 0,8'd0,0,32'h0);
    vecs[3]  = mk(1,0,32'h0,0,0,7'd0, 1,0,0,0,7'd0, 0,8'd0,0,32'h0);
    vecs[4]  = mk(0,1,32'h00000013,0,0,7'd0, 1,1,1,1,7'd0, 0,8'd1,0,32'h0);
    vecs[5]  = mk(0,1,32'h00100093,0,0,7'd0, 1,1,1,1,7'd1, 0,8'd2,0,32'h0);
    vecs[6]  = mk(0,1,32'h00200113,0,0,7'd0, 1,1,1,1,7'd2, 0,8'd3,0,32'h0);
    vecs[7]  = mk(0,1,32'h002081B3,1,0,7'd0, 1,1,1,1,7'd3, 1,8'd4,0,32'h0);
    vecs[8]  = mk(0,0,32'h0,0,1,7'd2, 0,0,0,1,7'd2, 0,8'd4,1,32'h00200113);
    vecs[9]  = mk(0,0,32'h0,0,1,7'd3, 0,0,0,1,7'd3, 0,8'd4,1,32'h002081B3);
    vecs[10] = mk(0,0,32'h0,0,1,7'd0, 0,0,0,1,7'd0, 0,8'd4,1,32'h00000013);
    vecs[11] = mk(0,0,32'h0,0,0,7'd0, 0,0,0,0,7'd0, 0,8'd4,0,32'h00000013);

    tick();
    tick();
    chk("rst_done", {31'b0, load_done}, 32'd0);
    chk("rst_cnt", {24'b0, load_count}, 32'd0);
    chk("rst_fv", {31'b0, fetch_valid}, 32'd0);
    chk("rst_fd", fetch_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ls, vecs[i].lv, vecs[i].ld, vecs[i].ll,
            vecs[i].fr, vecs[i].fa);
      chk($sformatf("v%0d_stall", i), {31'b0, cpu_stall}, {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d_ready", i), {31'b0, load_ready}, {31'b0, vecs[i].e_ready});
      chk($sformatf("v%0d_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_we});
      if (vecs[i].chk_addr)
        chk($sformatf("v%0d_addr", i), {25'b0, mem_addr}, {25'b0, vecs[i].e_addr});
      tick();
      chk($sformatf("v%0d_done", i), {31'b0, load_done}, {31'b0, vecs[i].e_done});
      chk($sformatf("v%0d_cnt", i), {24'b0, load_count}, {24'b0, vecs[i].e_cnt});
      chk($sformatf("v%0d_fv", i), {31'b0, fetch_valid}, {31'b0, vecs[i].e_fv});
      chk($sformatf("v%0d_fd", i), fetch_data, vecs[i].e_fd);
    end

    // full 128-word load without load_last
    drive(1, 0, 32'h0, 0, 0, 7'd0);
    tick();
    chk("full_cnt0", {24'b0, load_count}, 32'd0);
    chk("full_stall", {31'b0, cpu_stall}, 32'd1);
    for (int i = 0; i < 128; i++) begin
      drive(0, 1, 32'hA0000000 | i, 0, 0, 7'd0);
      chk($sformatf("full_addr%0d", i), {25'b0, mem_addr}, i);
      tick();
      if (i < 127)
        chk($sformatf("full_done%0d", i), {31'b0, load_done}, 32'd0);
    end
    chk("full_done", {31'b0, load_done}, 32'd1);
    chk("full_cnt", {24'b0, load_count}, 32'd128);
    drive(0, 1, 32'hDEADBEEF, 0, 0, 7'd0);
    chk("over_ready", {31'b0, load_ready}, 32'd0);
    chk("over_we", {31'b0, mem_we}, 32'd0);
    chk("over_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    chk("over_done", {31'b0, load_done}, 32'd0);
    chk("over_cnt", {24'b0, load_count}, 32'd128);
    drive(0, 0, 32'h0, 0, 1, 7'd0);
    tick();
    chk("full_fd0", fetch_data, 32'hA0000000);
    drive(0, 0, 32'h0, 0, 1, 7'd127);
    tick();
    chk("full_fv127", {31'b0, fetch_valid}, 32'd1);
    chk("full_fd127", fetch_data, 32'hA000007F);

    // restart from RUN beats a same-cycle fetch
    drive(1, 0, 32'h0, 0, 1, 7'd5);
    tick();
    chk("rs_fv", {31'b0, fetch_valid}, 32'd0);
    chk("rs_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rs_cnt", {24'b0, load_count}, 32'd0);
    drive(0, 1, 32'h00000055, 1, 0, 7'd0);
    chk("rs_addr", {25'b0, mem_addr}, 32'd0);
    chk("rs_we", {31'b0, mem_we}, 32'd1);
    tick();
    chk("rs_done", {31'b0, load_done}, 32'd1);
    chk("rs_cnt1", {24'b0, load_count}, 32'd1);
    drive(0, 0, 32'h0, 0, 1, 7'd0);
    tick();
    chk("rs_fd", fetch_data, 32'h00000055);

    // reset in the middle of a 5-beat load
    drive(1, 0, 32'h0, 0, 0, 7'd0);
    tick();
    drive(0, 1, 32'h11, 0, 0, 7'd0);
    tick();
    drive(0, 1, 32'h22, 0, 0, 7'd0);
    tick();
    chk("mr_cnt2", {24'b0, load_count}, 32'd2);
    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 7'd0);
    tick();
    chk("mr_cnt", {24'b0, load_count}, 32'd0);
    chk("mr_done", {31'b0, load_done}, 32'd0);
    chk("mr_stall", {31'b0, cpu_stall}, 32'd1);
    chk("mr_ready", {31'b0, load_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("mr_done2", {31'b0, load_done}, 32'd0);
    chk("mr_boot_ready", {31'b0, load_ready}, 32'd0);
    drive(1, 0, 32'h0, 0, 0, 7'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h100 + i, (i == 4), 0, 7'd0);
      chk($sformatf("ml_addr%0d", i), {25'b0, mem_addr}, i);
      tick();
    end
    chk("ml_done", {31'b0, load_done}, 32'd1);
    chk("ml_cnt", {24'b0, load_count}, 32'd5);
    drive(0, 0, 32'h0, 0, 1, 7'd4);
    tick();
    chk("ml_done_off", {31'b0, load_done}, 32'd0);
    chk("ml_fd4", fetch_data, 32'h00000104);
    drive(0, 0, 32'h0, 0, 1, 7'd0);
    tick();
    chk("ml_fd0", fetch_data, 32'h00000100);
    drive(0, 0, 32'h0, 0, 0, 7'd0);
    tick();
    chk("ml_fv_off", {31'b0, fetch_valid}, 32'd0);
    chk("ml_fd_hold", fetch_data, 32'h00000100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Owns the single port of the 128x32 instruction memory and shares it between two users: a boot-load stream that writes a program into memory, and the CPU fetch path that reads it. An FSM holds the CPU stalled until a program has been loaded, then hands the memory to fetch. Sits between the top-level program loader/testbench, the CPU fetch stage and the instruction memory.

Parameters:
n, 32, instruction/data word width in bits
r, 7, memory address width in bits; depth = 2^r words (128 by default)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
load_start  input  1  request to begin or restart a program load at address 0
load_valid  input  1  load_data holds a valid program word
load_data  input  n  program word to write
load_last  input  1  qualifies load_data as the final word of the program
load_ready  output  1  controller accepts a load beat this cycle
load_done  output  1  one-cycle pulse when a load completes
load_count  output  r+1  number of words written by the most recent load
fetch_req  input  1  CPU requests the instruction at fetch_addr
fetch_addr  input  r  word address of the fetch
fetch_valid  output  1  fetch_data is valid (one cycle after an accepted fetch_req)
fetch_data  output  n  registered instruction word
cpu_stall  output  1  CPU must hold its PC and not issue fetches
mem_we  output  1  write enable to the instruction memory
mem_addr  output  r  address to the instruction memory
mem_wdata  output  n  write data to the instruction memory
mem_rdata  input  n  combinational read data from the instruction memory

Behaviour:
- States: BOOT, LOAD, RUN. Encoding is free.
- Reset values: state BOOT, write pointer 0, load_count 0, load_done 0, fetch_valid 0, fetch_data 0. Combinational outputs in BOOT: cpu_stall 1, load_ready 0, mem_we 0.
- BOOT:
  - cpu_stall=1, load_ready=0; load_valid and fetch_req are ignored.
  - load_start -> LOAD next cycle; write pointer <= 0; load_count <= 0.
- LOAD:
  - cpu_stall=1, load_ready=1.
  - Port mux is combinational: mem_we = load_valid, mem_addr = write pointer, mem_wdata = load_data.
  - On each accepted beat (load_valid & load_ready): write pointer++, load_count++.
  - Accepted beat with load_last=1, or accepted beat at address 2^r-1 -> RUN next cycle, with load_done=1 for exactly that cycle.
  - Beats beyond capacity are never accepted, because load_ready drops on leaving LOAD.
  - load_start is ignored while in LOAD.
- RUN:
  - cpu_stall=0, load_ready=0, mem_we=0, mem_addr = fetch_addr.
  - fetch_req=1 -> next cycle fetch_valid=1 and fetch_data = mem_rdata sampled at the request edge. Latency is exactly 1 cycle, back-to-back requests give one result per cycle.
  - fetch_req=0 -> fetch_valid=0 next cycle; fetch_data holds its last value.
- Load restart from RUN:
  - load_start in RUN -> LOAD next cycle, write pointer <= 0, load_count <= 0.
  - load_start takes priority over a same-cycle fetch_req: that fetch is dropped and fetch_valid=0 next cycle.
  - cpu_stall is asserted from the cycle after load_start.
- load_count width is r+1, so a full load reports 2^r (128) with no wrap.
- mem_we is never asserted outside LOAD, and never together with a fetch.
- Reset mid-load: returns to BOOT, load_count=0, no load_done pulse. Memory contents already written persist, since the memory has no reset.

Test Plan:
- Reset, then 3 idle cycles -> cpu_stall=1, load_ready=0, fetch_valid=0, mem_we=0. A fetch_req in BOOT gives no fetch_valid.
- load_start; 4 beats 0x00000013, 0x00100093, 0x00200113, 0x002081B3 with last on beat 4 -> mem writes at addresses 0..3, load_done pulses 1 cycle after beat 4, load_count=4, state RUN, cpu_stall=0.
- In RUN, fetch_req on addresses 2,3,0 in consecutive cycles -> fetch_valid 1 on the following 3 cycles with 0x00200113, 0x002081B3, 0x00000013.
- Load 128 beats with load_last never set -> transition to RUN after beat 128, load_count=128. A 129th load_valid sees load_ready=0 and no write.
- Same-cycle load_start and fetch_req in RUN -> no fetch_valid next cycle, cpu_stall=1, the next load beat writes address 0.
- reset asserted after 2 of 5 load beats -> BOOT next cycle, load_count=0, no load_done. A subsequent full load of 5 beats gives load_count=5.
